// File: rtl/note_sequencer_if.sv
// ---------------------------------------------------------------------------
// note_sequencer_if
// Control and status bundle for the note sequencer.
//   note_in     [2:0] : note code to record (0 = rest, 1..7 = A..G)
//   load              : one-cycle pulse, record note_in
//   play              : one-cycle pulse, start playback
//   stop              : one-cycle pulse, abort playback
//   clear             : one-cycle pulse, empty the store
//   repeat_mode       : level, loop playback while high ('repeat' is a
//                       reserved word, hence the longer name)
//   note_out    [2:0] : note code to the tone generator, 0 = silent
//   playing           : high while a note or a gap is being played
//   count             : number of stored notes
//   full              : high when count == DEPTH
// Modports: master drives the controls, slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface note_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]    note_in;
  logic          load;
  logic          play;
  logic          stop;
  logic          clear;
  logic          repeat_mode;
  logic [2:0]    note_out;
  logic          playing;
  logic [CW-1:0] count;
  logic          full;

  modport master (
    output note_in, load, play, stop, clear, repeat_mode,
    input  note_out, playing, count, full
  );

  modport slave (
    input  note_in, load, play, stop, clear, repeat_mode,
    output note_out, playing, count, full
  );
endinterface

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
// Records up to DEPTH note codes and plays them back in order, each note
// held for NOTE_TICKS cycles followed by GAP_TICKS cycles of silence,
// optionally looping while repeat_mode is high.
// Ports:
//   CLOCK_50 : clock, all state updates on the rising edge
//   reset    : synchronous, active-high reset
//   bus      : note_sequencer_if.slave (controls in, note/status out)
// Event priority in a cycle: reset > stop > play > clear > load.
// ---------------------------------------------------------------------------
module note_sequencer #(
  parameter int DEPTH      = 16,
  parameter int NOTE_TICKS = 12500000,
  parameter int GAP_TICKS  = 2500000
) (
  input logic              CLOCK_50,
  input logic              reset,
  note_sequencer_if.slave  bus
);
  localparam int              AW         = $clog2(DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [31:0]     NOTE_LAST  = 32'(NOTE_TICKS - 1);
  localparam logic [31:0]     GAP_LAST   = 32'(GAP_TICKS - 1);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
  localparam bit              HAS_GAP    = (GAP_TICKS != 0);

  typedef enum logic [1:0] {
    IDLE,
    PLAY_NOTE,
    PLAY_GAP
  } state_t;

  state_t        r_state;
  logic [2:0]    r_store [DEPTH];
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_timer;
  logic [2:0]    r_note_out;
  logic          r_playing;
  logic          r_full;

  logic          w_last;
  logic [AW-1:0] w_next_idx;
  logic [AW-1:0] w_write_idx;
  logic          w_advance;

  // Read index sits on the final stored note (only meaningful when count > 0).
  assign w_last      = ({1'b0, r_idx} == (r_count - CW'(1)));
  assign w_next_idx  = r_idx + AW'(1);
  assign w_write_idx = r_count[AW-1:0];

  // End of the silence after a note; with no gap configured the decision
  // moves to the last cycle of the note itself.
  assign w_advance = ((r_state == PLAY_GAP) && (r_timer == GAP_LAST)) ||
                     ((r_state == PLAY_NOTE) && (r_timer == NOTE_LAST) && !HAS_GAP);

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others, like real flops.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // NOTE: the note store is deliberately left out of reset; count = 0
      // guarantees stale slots are never read before being rewritten.
      r_state    <= IDLE;
      r_count    <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_note_out <= '0;
      r_playing  <= 1'b0;
      r_full     <= 1'b0;
    end else if ((r_state != IDLE) && bus.stop) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_timer    <= '0;
      r_note_out <= '0;
      r_playing  <= 1'b0;
    end else if (w_advance) begin
      r_timer <= '0;
      if (!w_last) begin
        r_idx      <= w_next_idx;
        r_note_out <= r_store[w_next_idx];
        r_state    <= PLAY_NOTE;
      end else if (bus.repeat_mode) begin
        r_idx      <= '0;
        r_note_out <= r_store[0];
        r_state    <= PLAY_NOTE;
      end else begin
        r_idx      <= '0;
        r_note_out <= '0;
        r_playing  <= 1'b0;
        r_state    <= IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.play && (r_count != '0)) begin
            r_state    <= PLAY_NOTE;
            r_idx      <= '0;
            r_timer    <= '0;
            r_note_out <= r_store[0];
            r_playing  <= 1'b1;
          end else if (bus.clear) begin
            r_count <= '0;
            r_full  <= 1'b0;
          end else if (bus.load && !r_full) begin
            r_store[w_write_idx] <= bus.note_in;
            r_count              <= r_count + CW'(1);
            r_full               <= ((r_count + CW'(1)) == FULL_COUNT);
          end
        end
        PLAY_NOTE: begin
          // Only reached with a gap configured; the no-gap end is w_advance.
          if (r_timer == NOTE_LAST) begin
            r_state    <= PLAY_GAP;
            r_timer    <= '0;
            r_note_out <= '0;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        PLAY_GAP: begin
          r_timer <= r_timer + 32'd1;
        end
        default: begin
          r_state    <= IDLE;
          r_note_out <= '0;
          r_playing  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.note_out = r_note_out;
  assign bus.playing  = r_playing;
  assign bus.count    = r_count;
  assign bus.full     = r_full;

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
// Directed bench for note_sequencer with DEPTH=4, NOTE_TICKS=4, GAP_TICKS=2.
// Expected note_out sequences are written out by hand per scenario.
// ---------------------------------------------------------------------------
module tb_note_sequencer;
  logic clk;
  logic reset;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q [$];

  note_sequencer_if #(.DEPTH(4)) bus ();

  note_sequencer #(
    .DEPTH      (4),
    .NOTE_TICKS (4),
    .GAP_TICKS  (2)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_note(input logic [2:0] v);
    bus.note_in = v;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  task automatic pulse_play();
    bus.play = 1'b1;
    tick();
    bus.play = 1'b0;
  endtask

  // Walks exp_q one cycle at a time, expecting playback active throughout.
  task automatic run_expect(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      check({tag, " note_out"}, 32'(bus.note_out), 32'(exp_q[i]));
      check({tag, " playing"}, 32'(bus.playing), 32'd1);
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle note_out"}, 32'(bus.note_out), 32'd0);
    check({tag, " idle playing"}, 32'(bus.playing), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.note_in     = '0;
    bus.load        = 1'b0;
    bus.play        = 1'b0;
    bus.stop        = 1'b0;
    bus.clear       = 1'b0;
    bus.repeat_mode = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_idle("reset");
    check("reset count", 32'(bus.count), 32'd0);
    check("reset full", 32'(bus.full), 32'd0);

    // Play with an empty store is ignored
    pulse_play();
    check_idle("empty play");
    check("empty play count", 32'(bus.count), 32'd0);

    // Three notes including a rest, no repeat
    load_note(3'd3);
    load_note(3'd5);
    load_note(3'd0);
    check("three count", 32'(bus.count), 32'd3);
    check("three full", 32'(bus.full), 32'd0);
    pulse_play();
    exp_q = '{3,3,3,3,0,0, 5,5,5,5,0,0, 0,0,0,0,0,0};
    run_expect("three");
    check_idle("three end");
    check("three count after", 32'(bus.count), 32'd3);

    // Clear in idle, then fill past capacity
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clear count", 32'(bus.count), 32'd0);
    load_note(3'd1);
    load_note(3'd2);
    load_note(3'd3);
    check("fill full at 3", 32'(bus.full), 32'd0);
    load_note(3'd4);
    check("fill full at 4", 32'(bus.full), 32'd1);
    check("fill count at 4", 32'(bus.count), 32'd4);
    load_note(3'd7);
    check("fill count after 5th", 32'(bus.count), 32'd4);
    check("fill full after 5th", 32'(bus.full), 32'd1);
    pulse_play();
    exp_q = '{1,1,1,1,0,0, 2,2,2,2,0,0, 3,3,3,3,0,0, 4,4,4,4,0,0};
    run_expect("fill");
    check_idle("fill end");

    // Single note on repeat; clear/load/play during playback are ignored
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    load_note(3'd6);
    bus.repeat_mode = 1'b1;
    pulse_play();
    exp_q = '{6,6,6,6,0,0, 6,6,6,6,0,0, 6,6,6,6,0,0};
    run_expect("loop");
    bus.clear   = 1'b1;
    bus.load    = 1'b1;
    bus.play    = 1'b1;
    bus.note_in = 3'd5;
    exp_q = '{6,6};
    run_expect("loop busy");
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    bus.play  = 1'b0;
    check("loop busy count", 32'(bus.count), 32'd1);
    bus.repeat_mode = 1'b0;
    exp_q = '{6,6,0,0};
    run_expect("loop drop");
    check_idle("loop end");

    // Stop on the second cycle of the second note, then replay from the top
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    load_note(3'd2);
    load_note(3'd4);
    pulse_play();
    exp_q = '{2,2,2,2,0,0, 4};
    run_expect("stop pre");
    check("stop 2nd cycle", 32'(bus.note_out), 32'd4);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_idle("stop");
    check("stop count", 32'(bus.count), 32'd2);
    pulse_play();
    exp_q = '{2,2,2,2,0,0, 4,4,4,4,0,0};
    run_expect("replay");
    check_idle("replay end");

    // Reset in the middle of a note
    pulse_play();
    exp_q = '{2,2,2,2,0,0, 4};
    run_expect("rst pre");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midrst");
    check("midrst count", 32'(bus.count), 32'd0);
    check("midrst full", 32'(bus.full), 32'd0);
    pulse_play();
    check_idle("midrst play");
    tick();
    check_idle("midrst play+1");

    // Rewrite, then play and load in the same cycle: play wins
    load_note(3'd7);
    check("rewrite count", 32'(bus.count), 32'd1);
    bus.note_in = 3'd3;
    bus.load    = 1'b1;
    bus.play    = 1'b1;
    tick();
    bus.load    = 1'b0;
    bus.play    = 1'b0;
    exp_q = '{7,7,7,7,0,0};
    run_expect("playload");
    check_idle("playload end");
    check("playload count", 32'(bus.count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16: number of note slots (power of two, >=2).
REQ-002 The block SHALL have parameter NOTE_TICKS, default 12500000: CLOCK_50 cycles a note is held (0.25 s).
REQ-003 The block SHALL have parameter GAP_TICKS, default 2500000: CLOCK_50 cycles of silence after each note.
REQ-004 The block SHALL have port CLOCK_50 as a 1-bit input: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port reset as a 1-bit input: synchronous, active-high reset.
REQ-006 The block SHALL have port note_in as a 3-bit input: note code to record (0 = rest, 1..7 = A..G).
REQ-007 The block SHALL have port load as a 1-bit input: single-cycle pulse that records note_in.
REQ-008 The block SHALL have port play as a 1-bit input: single-cycle pulse that starts playback.
REQ-009 The block SHALL have port stop as a 1-bit input: single-cycle pulse that aborts playback.
REQ-010 The block SHALL have port clear as a 1-bit input: single-cycle pulse that empties the store.
REQ-011 The block SHALL have port repeat as a 1-bit input: level signal; when high, playback loops.
REQ-012 The block SHALL have port note_out as a 3-bit output: note code feeding the tone generator; 0 = silent.
REQ-013 The block SHALL have port playing as a 1-bit output: high while in PLAY_NOTE or PLAY_GAP.
REQ-014 The block SHALL have port count as a log2(DEPTH)+1-bit output: number of stored notes.
REQ-015 The block SHALL have port full as a 1-bit output: high when count == DEPTH.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, PLAY_NOTE and PLAY_GAP, plus a DEPTH x 3-bit note store, a write pointer (= count), a read index and a 32-bit tick timer.
REQ-017 In IDLE, when load is high and full is low, the block SHALL write note_in to slot count, and count SHALL increment on the next edge.
REQ-018 The block SHALL ignore load when full is high or when not in IDLE, with no store or count change.
REQ-019 In IDLE, clear SHALL set count to 0; clear SHALL be ignored outside IDLE; stored slot contents need not be erased.
REQ-020 In IDLE with count > 0, play SHALL move the block to PLAY_NOTE with read index 0 and timer 0, and note_out SHALL equal slot 0 in the following cycle (1-cycle latency).
REQ-021 In IDLE with count == 0, play SHALL be ignored.
REQ-022 In PLAY_NOTE, note_out SHALL equal slot[read index]; after exactly NOTE_TICKS cycles in PLAY_NOTE, the block SHALL enter PLAY_GAP with timer 0.
REQ-023 In PLAY_GAP, note_out SHALL be 0; after exactly GAP_TICKS cycles, if read index < count-1, the read index SHALL increment and the block SHALL enter PLAY_NOTE.
REQ-024 At the end of the gap after the last note, if repeat is high (sampled that cycle), the read index SHALL go to 0 and the block SHALL enter PLAY_NOTE; otherwise it SHALL enter IDLE.
REQ-025 If GAP_TICKS == 0, the block SHALL skip PLAY_GAP and apply the REQ-023/024 decision at the end of PLAY_NOTE.
REQ-026 A stop pulse in PLAY_NOTE or PLAY_GAP SHALL move the block to IDLE on the next edge, with note_out = 0 and playing = 0 from that edge; count SHALL be unchanged.
REQ-027 Simultaneous events SHALL be resolved with priority reset > stop > play > clear > load; only the highest-priority applicable event takes effect in a cycle.
REQ-028 play asserted while already playing SHALL be ignored (no restart).
REQ-029 In IDLE, note_out SHALL be 0 and playing SHALL be 0.
REQ-030 A stored rest (code 0) SHALL play as 0 for NOTE_TICKS cycles, like any note.
REQ-031 The timer SHALL count 0..N-1 and never wrap during a phase; the read index SHALL never reach count.

Reset
REQ-032 On reset high at a clock edge, the block SHALL set: state IDLE, count 0, read index 0, timer 0, note_out 0, playing 0, full 0.
REQ-033 Reset SHALL take effect from any state, including mid-note, and override all other inputs in the same cycle.
REQ-034 Store contents after reset are don't-care and SHALL never be played before being rewritten.

Verification (bench uses DEPTH=4, NOTE_TICKS=4, GAP_TICKS=2)
REQ-035 Load 3,5,0 then play, repeat=0 -> note_out = 3x4, 0x2, 5x4, 0x2, 0x4, 0x2 cycles, then IDLE; playing high for exactly 18 cycles; count stays 3.
REQ-036 Load 1,2,3,4,7 -> full high after the 4th load; the 5th load is ignored; count = 4; playback never shows 7.
REQ-037 Load 6, play, repeat=1 -> 6x4, 0x2 pattern repeats for at least 3 loops; drop repeat mid-note -> IDLE after that loop's gap.
REQ-038 Load 2,4, play, stop on the 2nd cycle of note 4 -> next cycle note_out = 0 and playing = 0; replay starts at note 2.
REQ-039 Reset asserted mid-PLAY_NOTE -> next cycle note_out = 0 and count = 0; play then ignored until a load occurs.
REQ-040 Play with count=0 -> no change; play+load in the same IDLE cycle -> playback starts and the load is discarded; clear during playback -> ignored, count unchanged.
